inport_buffer: RTL and testbench

//  Receive-side stage of a router link; consumes one neighbour outport's channel_dout and diff_pair_dout.

---
 rtl/inport_buffer_pkg.sv | 24 ++
 rtl/inport_flow_handler.sv | 46 ++++
 rtl/inport_buffer.sv | 86 ++++++++
 tb/tb_inport_buffer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/inport_buffer_pkg.sv
// Shared router-link definitions: flit geometry, idle pair encoding and pair helpers.
package inport_buffer_pkg;

    localparam int unsigned FLIT_WIDTH = 48;
    localparam logic [1:0]  PAIR_IDLE  = 2'b01;

    // Flit field layout as seen by the routing logic
    localparam int unsigned FLIT_DEST_LSB    = 40;
    localparam int unsigned FLIT_DEST_W      = 8;
    localparam int unsigned FLIT_SRC_LSB     = 32;
    localparam int unsigned FLIT_SRC_W       = 8;
    localparam int unsigned FLIT_PAYLOAD_LSB = 0;
    localparam int unsigned FLIT_PAYLOAD_W   = 32;

    typedef struct packed {
        logic p;
        logic n;
    } diff_pair_t;

    function automatic logic pair_legal(input diff_pair_t pair);
        return pair.p != pair.n;
    endfunction

endpackage

// File: rtl/inport_flow_handler.sv
// Receive mirror of the outport flow handler: tracks the last legal p level,
// flags each legal p transition as a flit arrival, and latches illegal pairs.
module inport_flow_handler
    import inport_buffer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] pair_i,
    output logic       arrive_c,
    output logic       pair_err_o
);

    diff_pair_t pair;
    logic       legal;
    logic       prev_p_q, prev_p_d;
    logic       pair_err_q, pair_err_d;

    assign pair = pair_i;

    always_comb begin
        legal      = pair_legal(pair);
        arrive_c   = 1'b0;
        prev_p_d   = prev_p_q;
        pair_err_d = pair_err_q;
        // An illegal pair is invisible to the edge detector; only the sticky flag sees it
        if (legal) begin
            arrive_c = (pair.p != prev_p_q);
            prev_p_d = pair.p;
        end else begin
            pair_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_p_q   <= 1'b0;
            pair_err_q <= 1'b0;
        end else begin
            prev_p_q   <= prev_p_d;
            pair_err_q <= pair_err_d;
        end
    end

    assign pair_err_o = pair_err_q;

endmodule

// File: rtl/inport_buffer.sv
// Receive-side link stage: captures one flit per pair transition into a small FIFO,
// presents the head with valid/ack and returns one credit per dequeued flit.
module inport_buffer
    import inport_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FLIT_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic [1:0]            diff_pair_din,
    input  logic [DATA_WIDTH-1:0] channel_din,
    output logic [DATA_WIDTH-1:0] head_dout,
    output logic                  head_valid_dout,
    input  logic                  head_ack_din,
    output logic                  credit_dout,
    output logic                  fifo_full_dout,
    output logic                  overflow_err_dout,
    output logic                  pair_err_dout
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  valid_q, full_q, credit_q;
    logic                  overflow_q, overflow_d;
    logic                  arrive_c, deq_c, wr_en_c;

    inport_flow_handler u_flow (
        .clk_i      (clka),
        .rst_i      (rsta),
        .pair_i     (diff_pair_din),
        .arrive_c   (arrive_c),
        .pair_err_o (pair_err_dout)
    );

    // A full FIFO still accepts an arrival when the head leaves on the same edge
    always_comb begin
        deq_c      = valid_q && head_ack_din;
        wr_en_c    = arrive_c && (!full_q || deq_c);
        overflow_d = overflow_q | (arrive_c && full_q && !deq_c);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (wr_en_c) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (deq_c)   rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        case ({wr_en_c, deq_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            full_q     <= 1'b0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en_c) mem_q[wr_ptr_q] <= channel_din;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= (count_d != '0);
            full_q     <= (count_d == CNT_W'(FIFO_DEPTH));
            credit_q   <= deq_c;
            overflow_q <= overflow_d;
        end
    end

    assign head_dout         = mem_q[rd_ptr_q];
    assign head_valid_dout   = valid_q;
    assign fifo_full_dout    = full_q;
    assign credit_dout       = credit_q;
    assign overflow_err_dout = overflow_q;

endmodule

// File: tb/tb_inport_buffer.sv
// Directed vector bench for inport_buffer: table of per-cycle inputs and expected outputs
// plus hand sequences for reset behaviour.
module tb_inport_buffer;

    logic        clka = 1'b0;
    logic        rsta;
    logic [1:0]  diff_pair_din;
    logic [47:0] channel_din;
    logic [47:0] head_dout;
    logic        head_valid_dout;
    logic        head_ack_din;
    logic        credit_dout;
    logic        fifo_full_dout;
    logic        overflow_err_dout;
    logic        pair_err_dout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  pair;
        logic [47:0] din;
        logic        ack;
        logic        ev;
        logic [47:0] eh;
        logic        ch;
        logic        ef;
        logic        ec;
        logic        eo;
        logic        ep;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    inport_buffer #(
        .DATA_WIDTH (48),
        .FIFO_DEPTH (4),
        .ADDR_WIDTH (2)
    ) dut (
        .clka              (clka),
        .rsta              (rsta),
        .diff_pair_din     (diff_pair_din),
        .channel_din       (channel_din),
        .head_dout         (head_dout),
        .head_valid_dout   (head_valid_dout),
        .head_ack_din      (head_ack_din),
        .credit_dout       (credit_dout),
        .fifo_full_dout    (fifo_full_dout),
        .overflow_err_dout (overflow_err_dout),
        .pair_err_dout     (pair_err_dout)
    );

    always #5 clka = ~clka;

    function automatic vec_t mk(input logic [1:0] p, input logic [47:0] d, input logic a,
                                input logic v, input logic [47:0] h, input logic ch,
                                input logic f, input logic c, input logic o, input logic e);
        vec_t r;
        r.pair = p; r.din = d; r.ack = a; r.ev = v; r.eh = h; r.ch = ch;
        r.ef = f; r.ec = c; r.eo = o; r.ep = e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [1:0] p, input logic [47:0] d, input logic a);
        diff_pair_din = p;
        channel_din   = d;
        head_ack_din  = a;
        @(posedge clka);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [47:0] h, input logic ch,
                           input logic f, input logic c, input logic o, input logic e);
        chk({tag, ".valid"},  64'(head_valid_dout),   64'(v));
        if (ch) chk({tag, ".head"}, 64'(head_dout), 64'(h));
        chk({tag, ".full"},   64'(fifo_full_dout),    64'(f));
        chk({tag, ".credit"}, 64'(credit_dout),       64'(c));
        chk({tag, ".ovf"},    64'(overflow_err_dout), 64'(o));
        chk({tag, ".perr"},   64'(pair_err_dout),     64'(e));
    endtask

    initial begin
        // Single-flit transfer, fill to full, ack-while-full, drop, drain, empty corners, illegal pair
        vecs[0]  = mk(2'b10, 48'hA5A5_0000_0001, 1'b0, 1, 48'hA5A5_0000_0001, 1, 0, 0, 0, 0);
        vecs[1]  = mk(2'b10, 48'h0,              1'b0, 1, 48'hA5A5_0000_0001, 1, 0, 0, 0, 0);
        vecs[2]  = mk(2'b10, 48'h0,              1'b1, 0, 48'h0,              1, 0, 1, 0, 0);
        vecs[3]  = mk(2'b10, 48'h0,              1'b0, 0, 48'h0,              1, 0, 0, 0, 0);
        vecs[4]  = mk(2'b01, 48'h1,              1'b0, 1, 48'h1,              1, 0, 0, 0, 0);
        vecs[5]  = mk(2'b10, 48'h2,              1'b0, 1, 48'h1,              1, 0, 0, 0, 0);
        vecs[6]  = mk(2'b01, 48'h3,              1'b0, 1, 48'h1,              1, 0, 0, 0, 0);
        vecs[7]  = mk(2'b10, 48'h4,              1'b0, 1, 48'h1,              1, 1, 0, 0, 0);
        vecs[8]  = mk(2'b01, 48'h5,              1'b1, 1, 48'h2,              1, 1, 1, 0, 0);
        vecs[9]  = mk(2'b10, 48'h6,              1'b0, 1, 48'h2,              1, 1, 0, 1, 0);
        vecs[10] = mk(2'b10, 48'h0,              1'b1, 1, 48'h3,              1, 0, 1, 1, 0);
        vecs[11] = mk(2'b10, 48'h0,              1'b1, 1, 48'h4,              1, 0, 1, 1, 0);
        vecs[12] = mk(2'b10, 48'h0,              1'b1, 1, 48'h5,              1, 0, 1, 1, 0);
        vecs[13] = mk(2'b10, 48'h0,              1'b1, 0, 48'h0,              0, 0, 1, 1, 0);
        vecs[14] = mk(2'b10, 48'h0,              1'b1, 0, 48'h0,              0, 0, 0, 1, 0);
        vecs[15] = mk(2'b01, 48'h7,              1'b1, 1, 48'h7,              1, 0, 0, 1, 0);
        vecs[16] = mk(2'b01, 48'h0,              1'b1, 0, 48'h0,              0, 0, 1, 1, 0);
        vecs[17] = mk(2'b11, 48'h8,              1'b0, 0, 48'h0,              0, 0, 0, 1, 1);
        vecs[18] = mk(2'b10, 48'h9,              1'b0, 1, 48'h9,              1, 0, 0, 1, 1);
        vecs[19] = mk(2'b10, 48'h0,              1'b1, 0, 48'h0,              0, 0, 1, 1, 1);
        vecs[20] = mk(2'b10, 48'h0,              1'b0, 0, 48'h0,              0, 0, 0, 1, 1);

        rsta = 1'b1;
        diff_pair_din = 2'b01;
        channel_din = '0;
        head_ack_din = 1'b0;
        repeat (2) @(posedge clka);
        #1;
        chk_all("reset", 0, 48'h0, 1, 0, 0, 0, 0);

        rsta = 1'b0;
        for (int i = 0; i < 10; i++) step(2'b01, 48'h0, 1'b0);
        chk_all("idle", 0, 48'h0, 1, 0, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].pair, vecs[i].din, vecs[i].ack);
            chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eh, vecs[i].ch,
                    vecs[i].ef, vecs[i].ec, vecs[i].eo, vecs[i].ep);
        end

        // Reset mid-stream with three flits buffered and ack held high
        step(2'b01, 48'hB1, 1'b0);
        step(2'b10, 48'hB2, 1'b0);
        step(2'b01, 48'hB3, 1'b0);
        chk_all("pre_rst", 1, 48'hB1, 1, 0, 0, 1, 1);
        rsta = 1'b1;
        step(2'b01, 48'h0, 1'b1);
        chk_all("mid_rst", 0, 48'h0, 1, 0, 0, 0, 0);
        rsta = 1'b0;
        step(2'b01, 48'h0, 1'b1);
        chk_all("post_rst1", 0, 48'h0, 1, 0, 0, 0, 0);
        step(2'b01, 48'h0, 1'b1);
        chk("post_rst2.credit", 64'(credit_dout), 64'(0));
        step(2'b10, 48'hC1, 1'b0);
        chk_all("post_rst_flit", 1, 48'hC1, 1, 0, 0, 0, 0);
        step(2'b10, 48'h0, 1'b1);
        chk_all("post_rst_deq", 0, 48'h0, 0, 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
